// File: rtl/level_8_sort_pack.sv
// level_8_sort_pack
// Producer side of the level-8 median stage. Accepts a frame of 2*N_HALF
// unsigned samples and insertion-sorts them into two independent halves,
// A (first N_HALF samples) and B (last N_HALF samples). Each half is stored
// ascending by index, so index N_HALF-1 holds the largest value. The packed
// frame {B, A} is presented on odata with a one-cycle ovalid pulse.
module level_8_sort_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int N_HALF     = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          idata,
  input  logic                           ivalid,
  output logic [2*N_HALF*DATA_WIDTH-1:0] odata,
  output logic                           ovalid,
  output logic [$clog2(2*N_HALF):0]      ocnt
);

  localparam int FRAME = 2 * N_HALF;
  localparam int CW    = $clog2(FRAME) + 1;

  typedef logic [N_HALF-1:0][DATA_WIDTH-1:0] half_t;

  typedef enum logic [1:0] {
    FILL_A,
    FILL_B,
    EMIT
  } state_t;

  state_t state;
  half_t  buf_a;
  half_t  buf_b;

  // One parallel insertion step. Entries above the insertion point shift
  // down by one; the slot at the insertion point takes v. Strict '>' keeps
  // a new value below any equal value already present. The old index-0
  // entry falls off the bottom, which is always an empty (zero) slot.
  function automatic half_t insert(input half_t b, input logic [DATA_WIDTH-1:0] v);
    half_t r;
    r = b;
    for (int i = 0; i < N_HALF - 1; i++) begin
      if (v > b[i+1])
        r[i] = b[i+1];
      else if (v > b[i])
        r[i] = v;
    end
    if (v > b[N_HALF-1])
      r[N_HALF-1] = v;
    return r;
  endfunction

  // Frame sequencing, sorting and output registers.
  // EMIT behaves like FILL_A with an empty A, so a sample presented during
  // the output pulse starts the next frame instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL_A;
      // NOTE: the sort buffers are reset because the insertion compare relies
      // on empty slots reading as 0; an unreset buffer would leak X or stale data.
      buf_a  <= '0;
      buf_b  <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
      ocnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, regardless of statement order.
      ovalid <= 1'b0;
      case (state)
        FILL_A, EMIT: begin
          if (ivalid) begin
            buf_a <= insert(buf_a, idata);
            ocnt  <= ocnt + CW'(1);
            state <= (ocnt == CW'(N_HALF - 1)) ? FILL_B : FILL_A;
          end else begin
            state <= FILL_A;
          end
        end
        FILL_B: begin
          if (ivalid) begin
            if (ocnt == CW'(FRAME - 1)) begin
              // Last sample of the frame: publish and start clean.
              odata  <= {insert(buf_b, idata), buf_a};
              ovalid <= 1'b1;
              buf_a  <= '0;
              buf_b  <= '0;
              ocnt   <= '0;
              state  <= EMIT;
            end else begin
              buf_b <= insert(buf_b, idata);
              ocnt  <= ocnt + CW'(1);
            end
          end
        end
        default: state <= FILL_A;
      endcase
    end
  end

endmodule

// File: tb/tb_level_8_sort_pack.sv
// tb_level_8_sort_pack
// Directed and short randomised frames for level_8_sort_pack. Expected
// frames are either hand-derived formulas or a plain software sort of
// each half of the sample list.
module tb_level_8_sort_pack;

  localparam int DW    = 8;
  localparam int NH    = 128;
  localparam int FRAME = 2 * NH;
  localparam int CW    = $clog2(FRAME) + 1;
  localparam int OW    = 2 * NH * DW;
  localparam int HW    = NH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] idata = '0;
  logic          ivalid = 1'b0;
  logic [OW-1:0] odata;
  logic          ovalid;
  logic [CW-1:0] ocnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] smp [FRAME];
  logic [OW-1:0] want;
  logic [OW-1:0] want_prev;

  level_8_sort_pack #(.DATA_WIDTH(DW), .N_HALF(NH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .idata  (idata),
    .ivalid (ivalid),
    .odata  (odata),
    .ovalid (ovalid),
    .ocnt   (ocnt)
  );

  always #5 clk = ~clk;

  // Free-running edge counter.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts ovalid pulses and tracks the smallest spacing.
  int pulses     = 0;
  int last_pulse = -1;
  int min_gap    = 1 << 30;
  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap)
        min_gap <= cyc - last_pulse;
      last_pulse <= cyc;
      pulses     <= pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares each half of odata against the expected frame.
  task automatic check_frame(input string tag, input logic [OW-1:0] exp);
    for (int h = 0; h < 2; h++) begin
      int bad;
      bad = -1;
      for (int i = NH - 1; i >= 0; i--)
        if (odata[(h*NH+i)*DW +: DW] !== exp[(h*NH+i)*DW +: DW]) bad = i;
      n_assert++;
      assert (odata[h*HW +: HW] === exp[h*HW +: HW])
      else begin
        n_fail++;
        $error("FAIL %s half %s: slot %0d observed %0h expected %0h", tag,
               (h == 0) ? "A" : "B", bad,
               odata[(h*NH+((bad < 0) ? 0 : bad))*DW +: DW],
               exp[(h*NH+((bad < 0) ? 0 : bad))*DW +: DW]);
      end
    end
  endtask

  // Software model: bubble-sort each half of smp ascending into want.
  task automatic build_exp();
    logic [DW-1:0] s [NH];
    logic [DW-1:0] t;
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < NH; i++) s[i] = smp[h*NH+i];
      for (int p = 0; p < NH - 1; p++)
        for (int i = 0; i < NH - 1 - p; i++)
          if (s[i] > s[i+1]) begin
            t = s[i]; s[i] = s[i+1]; s[i+1] = t;
          end
      for (int i = 0; i < NH; i++) want[(h*NH+i)*DW +: DW] = s[i];
    end
  endtask

  task automatic send(input logic [DW-1:0] v);
    idata  = v;
    ivalid = 1'b1;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int p0;

    // ---- Reset state
    #2 rst_n = 1'b0;
    #1;
    want = '0;
    check_frame("reset_odata", want);
    check("reset_ovalid", 32'(ovalid), 32'd0);
    check("reset_ocnt", 32'(ocnt), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // ---- 1: ascending 0..255
    for (int i = 0; i < FRAME; i++) begin
      send(DW'(i));
      if (i == 0)   check("t1_ocnt_first", 32'(ocnt), 32'd1);
      if (i == 127) check("t1_ocnt_half", 32'(ocnt), 32'd128);
      if (i == 254) begin
        check("t1_no_early_ovalid", 32'(ovalid), 32'd0);
        check("t1_ocnt_top", 32'(ocnt), 32'd255);
      end
    end
    check("t1_ovalid", 32'(ovalid), 32'd1);
    check("t1_ocnt_wrap", 32'(ocnt), 32'd0);
    for (int i = 0; i < NH; i++) begin
      want[i*DW +: DW]      = DW'(i);
      want[(NH+i)*DW +: DW] = DW'(128 + i);
    end
    check_frame("t1_frame", want);
    idle(1);
    check("t1_ovalid_pulse_end", 32'(ovalid), 32'd0);
    check_frame("t1_frame_held", want);
    idle(3);

    // ---- 2: all fives, then all zeros
    for (int i = 0; i < FRAME; i++) send(8'd5);
    check("t2_fives_ovalid", 32'(ovalid), 32'd1);
    for (int i = 0; i < FRAME; i++) want[i*DW +: DW] = 8'd5;
    check_frame("t2_fives", want);
    idle(2);
    for (int i = 0; i < FRAME; i++) send(8'd0);
    check("t2_zeros_ovalid", 32'(ovalid), 32'd1);
    want = '0;
    check_frame("t2_zeros", want);
    idle(3);

    // ---- 3: descending 255..0 with a one-cycle gap after every sample
    c0 = 0;
    for (int k = 0; k < FRAME; k++) begin
      send(DW'(255 - k));
      if (k == 0) c0 = cyc;
      check("t3_ocnt", 32'(ocnt), 32'((k + 1) % FRAME));
      if (k != FRAME - 1) idle(1);
    end
    check("t3_ovalid", 32'(ovalid), 32'd1);
    check("t3_latency_edges", 32'(cyc - c0), 32'd510);
    for (int i = 0; i < NH; i++) begin
      want[i*DW +: DW]      = DW'(128 + i);
      want[(NH+i)*DW +: DW] = DW'(i);
    end
    check_frame("t3_frame", want);
    idle(3);

    // ---- 4: back-to-back frames, 0x11 accepted in the EMIT cycle
    for (int i = 0; i < FRAME; i++) smp[i] = DW'((i * 37 + 11) & 255);
    build_exp();
    want_prev = want;
    for (int i = 0; i < FRAME; i++) send(smp[i]);
    check("t4_f1_ovalid", 32'(ovalid), 32'd1);
    check_frame("t4_f1", want_prev);
    smp[0] = 8'h11;
    for (int i = 1; i < FRAME; i++) smp[i] = DW'((i * 91 + 3) & 255);
    build_exp();
    send(smp[0]);
    check("t4_emit_accept_ocnt", 32'(ocnt), 32'd1);
    check("t4_emit_pulse_end", 32'(ovalid), 32'd0);
    check_frame("t4_f1_held", want_prev);
    for (int i = 1; i < FRAME; i++) begin
      send(smp[i]);
      if (i == FRAME - 2) check("t4_f2_not_early", 32'(ovalid), 32'd0);
    end
    check("t4_f2_ovalid", 32'(ovalid), 32'd1);
    check_frame("t4_f2", want);
    idle(3);

    // ---- 5: reset after 100 samples, then a fresh frame
    for (int i = 0; i < 100; i++) send(DW'($urandom_range(1, 255)));
    rst_n = 1'b0;
    #1;
    want = '0;
    check_frame("t5_reset_odata", want);
    check("t5_reset_ocnt", 32'(ocnt), 32'd0);
    idle(3);
    check("t5_reset_ovalid", 32'(ovalid), 32'd0);
    p0 = pulses;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < FRAME; i++) smp[i] = DW'($urandom_range(0, 255));
    build_exp();
    for (int i = 0; i < FRAME; i++) send(smp[i]);
    check("t5_ovalid", 32'(ovalid), 32'd1);
    check_frame("t5_frame", want);
    idle(1);
    check("t5_single_pulse", 32'(pulses), 32'(p0 + 1));
    idle(2);

    // ---- 6: random frames with random ivalid gaps
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < FRAME; i++) smp[i] = DW'($urandom_range(0, 255));
      build_exp();
      for (int i = 0; i < FRAME; i++) begin
        send(smp[i]);
        if (i != FRAME - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      check("t6_ovalid", 32'(ovalid), 32'd1);
      check_frame("t6_frame", want);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(2);

    // ---- Pulse bookkeeping across the whole run
    check("total_pulses", 32'(pulses), 32'd37);
    check("ovalid_spacing_ok", 32'(min_gap >= FRAME), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
